st4_writeback: RTL and testbench

ST4_WRITEBACK -- requirements
Module: st4_writeback

---
 rtl/st4_writeback.sv | 113 +++++++++++
 tb/tb_st4_writeback.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/st4_writeback.sv
// rtl/st4_writeback.sv - ALU-to-register-file writeback stage with dual-result sequencing and exception capture.
module st4_writeback #(
  parameter logic [3:0] HI_REG = 4'd15,
  parameter int          DW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  output logic          ready,
  input  logic [1:0]    wb_op,
  input  logic [3:0]    rd1,
  input  logic [3:0]    rd2,
  input  logic [DW-1:0] aluOut1,
  input  logic [DW-1:0] aluOut2,
  input  logic          ALU_exception,
  input  logic [15:0]   pc_in,
  input  logic          exc_ack,
  output logic          rf_we,
  output logic [3:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          exc_flag,
  output logic [15:0]   epc,
  output logic          flush
);

  typedef enum logic [1:0] {IDLE, WR2, EXC} state_t;

  state_t        state, state_nx;
  logic [3:0]    sec_addr, sec_addr_nx;
  logic [DW-1:0] sec_data, sec_data_nx;
  logic          we_nx;
  logic [3:0]    waddr_nx;
  logic [DW-1:0] wdata_nx;
  logic          exc_nx;
  logic [15:0]   epc_nx;
  logic          flush_nx;
  logic          xfer;

  assign ready = (state == IDLE);
  assign xfer  = valid_in && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sec_addr <= '0;
      sec_data <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      exc_flag <= 1'b0;
      epc      <= '0;
      flush    <= 1'b0;
    end else begin
      state    <= state_nx;
      sec_addr <= sec_addr_nx;
      sec_data <= sec_data_nx;
      rf_we    <= we_nx;
      rf_waddr <= waddr_nx;
      rf_wdata <= wdata_nx;
      exc_flag <= exc_nx;
      epc      <= epc_nx;
      flush    <= flush_nx;
    end
  end

  // Writes to R0 keep their slot in the sequence but never assert the enable.
  always_comb begin
    state_nx    = state;
    sec_addr_nx = sec_addr;
    sec_data_nx = sec_data;
    we_nx       = 1'b0;
    waddr_nx    = rf_waddr;
    wdata_nx    = rf_wdata;
    exc_nx      = exc_flag;
    epc_nx      = epc;
    flush_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (ALU_exception) begin
            exc_nx   = 1'b1;
            epc_nx   = pc_in;
            flush_nx = 1'b1;
            state_nx = EXC;
          end else if (wb_op != 2'b00) begin
            we_nx    = (rd1 != 4'd0);
            waddr_nx = rd1;
            wdata_nx = aluOut1;
            if (wb_op[1]) begin
              sec_addr_nx = (wb_op == 2'b10) ? HI_REG : rd2;
              sec_data_nx = aluOut2;
              state_nx    = WR2;
            end
          end
        end
      end
      WR2: begin
        we_nx    = (sec_addr != 4'd0);
        waddr_nx = sec_addr;
        wdata_nx = sec_data;
        state_nx = IDLE;
      end
      EXC: begin
        if (exc_ack) begin
          exc_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_st4_writeback.sv
// tb/tb_st4_writeback.sv - scoreboard bench for st4_writeback.
module tb_st4_writeback;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          ready;
  logic [1:0]    wb_op;
  logic [3:0]    rd1, rd2;
  logic [DW-1:0] aluOut1, aluOut2;
  logic          ALU_exception;
  logic [15:0]   pc_in;
  logic          exc_ack;
  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          exc_flag;
  logic [15:0]   epc;
  logic          flush;

  st4_writeback #(.HI_REG(4'd15), .DW(DW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready), .wb_op(wb_op),
    .rd1(rd1), .rd2(rd2), .aluOut1(aluOut1), .aluOut2(aluOut2),
    .ALU_exception(ALU_exception), .pc_in(pc_in), .exc_ack(exc_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exc_flag(exc_flag), .epc(epc), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t wr_q[$];
  ev_t exc_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every write and every flush must match the head of its queue.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (wr_q.size() == 0) chk("unexpected_write", {28'd0, rf_waddr}, 32'hFFFF_FFFF);
      else begin
        ev_t e;
        e = wr_q.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", {28'd0, rf_waddr}, {28'd0, e.addr});
        chk("write_data", {16'd0, rf_wdata}, {16'd0, e.data});
      end
    end
    if (flush === 1'b1) begin
      if (exc_q.size() == 0) chk("unexpected_flush", 1, 0);
      else begin
        ev_t e;
        e = exc_q.pop_front();
        chk("flush_cycle", cyc, e.cyc);
        chk("flush_epc", {16'd0, epc}, {16'd0, e.data});
        chk("flush_exc_flag", {31'd0, exc_flag}, 1);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [15:0] d1, input logic [15:0] d2,
                      input logic exc, input logic [15:0] pc);
    int   guard;
    ev_t  e;
    logic [3:0] sa;
    valid_in = 1'b1; wb_op = op; rd1 = a1; rd2 = a2;
    aluOut1 = d1; aluOut2 = d2; ALU_exception = exc; pc_in = pc;
    guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    if (exc) begin
      e.cyc = cyc + 1; e.addr = 4'd0; e.data = pc;
      exc_q.push_back(e);
    end else if (op != 2'b00) begin
      if (a1 != 4'd0) begin
        e.cyc = cyc + 1; e.addr = a1; e.data = d1;
        wr_q.push_back(e);
      end
      if (op[1]) begin
        sa = (op == 2'b10) ? 4'd15 : a2;
        if (sa != 4'd0) begin
          e.cyc = cyc + 2; e.addr = sa; e.data = d2;
          wr_q.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; wb_op = 2'b00; rd1 = '0; rd2 = '0;
    aluOut1 = '0; aluOut2 = '0; ALU_exception = 1'b0; pc_in = '0; exc_ack = 1'b0;
    idle(2);
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_waddr", {28'd0, rf_waddr}, 0);
    chk("rst_wdata", {16'd0, rf_wdata}, 0);
    chk("rst_exc_flag", {31'd0, exc_flag}, 0);
    chk("rst_epc", {16'd0, epc}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", {31'd0, ready}, 1);

    // Single write; ready stays high
    send(2'b01, 4'd3, 4'd0, 16'h0007, 16'h0000, 1'b0, 16'h0000);
    chk("single_ready", {31'd0, ready}, 1);
    idle(1);

    // Dual: second write lands in HI_REG
    send(2'b10, 4'd2, 4'd9, 16'h0064, 16'h0000, 1'b0, 16'h0000);
    chk("dual_ready_low", {31'd0, ready}, 0);
    idle(2);

    // Swap with the next op held during WR2
    send(2'b11, 4'd4, 4'd5, 16'hAAAA, 16'h5555, 1'b0, 16'h0000);
    chk("swap_ready_low", {31'd0, ready}, 0);
    send(2'b01, 4'd6, 4'd0, 16'h1234, 16'h0000, 1'b0, 16'h0000);
    idle(2);

    // R0 suppression and no-op
    send(2'b01, 4'd0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);
    send(2'b00, 4'd7, 4'd8, 16'h1111, 16'h2222, 1'b0, 16'h0000);
    send(2'b11, 4'd0, 4'd8, 16'h3333, 16'h4444, 1'b0, 16'h0000);
    idle(1);
    send(2'b11, 4'd9, 4'd9, 16'h0101, 16'h0202, 1'b0, 16'h0000);
    idle(2);

    // Exception with a dual op: no writes, flush once, hold until ack
    send(2'b10, 4'd2, 4'd3, 16'hFFFE, 16'h0001, 1'b1, 16'h0010);
    chk("exc_flag_set", {31'd0, exc_flag}, 1);
    chk("exc_epc", {16'd0, epc}, 16'h0010);
    chk("exc_ready_low", {31'd0, ready}, 0);
    idle(3);
    chk("exc_flush_done", {31'd0, flush}, 0);
    chk("exc_held", {31'd0, exc_flag}, 1);
    exc_ack = 1'b1;
    idle(1);
    exc_ack = 1'b0;
    chk("exc_cleared", {31'd0, exc_flag}, 0);
    chk("exc_epc_kept", {16'd0, epc}, 16'h0010);
    chk("exc_ready_back", {31'd0, ready}, 1);
    exc_ack = 1'b1;
    idle(1);
    exc_ack = 1'b0;
    chk("ack_idle_ignored", {31'd0, ready}, 1);

    // Reset during WR2 discards the pending second write
    send(2'b10, 4'd7, 4'd0, 16'h00C0, 16'h00C1, 1'b0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    if (wr_q.size() > 0) void'(wr_q.pop_back());
    @(posedge clk); #1;
    chk("mid_rst_we", {31'd0, rf_we}, 0);
    chk("mid_rst_waddr", {28'd0, rf_waddr}, 0);
    chk("mid_rst_wdata", {16'd0, rf_wdata}, 0);
    chk("mid_rst_epc", {16'd0, epc}, 0);
    rst = 1'b0;
    idle(1);
    chk("mid_rst_ready", {31'd0, ready}, 1);

    // Reset in EXC clears the pending exception
    send(2'b01, 4'd1, 4'd0, 16'h0000, 16'h0000, 1'b1, 16'h0ABC);
    idle(1);
    rst = 1'b1; exc_ack = 1'b1;
    idle(1);
    rst = 1'b0; exc_ack = 1'b0;
    chk("exc_rst_flag", {31'd0, exc_flag}, 0);
    chk("exc_rst_epc", {16'd0, epc}, 0);
    idle(1);
    chk("exc_rst_ready", {31'd0, ready}, 1);

    // Random non-exception traffic
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           16'($urandom), 16'($urandom), 1'b0, 16'h0000);
    end
    idle(4);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("exc_q_drained", exc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
